// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - descriptor-table layer sequencer for the CNN layer datapath
// Walks a small table of per-layer descriptors, advancing once per rising edge of
// layer_ready, and reports how many cycles the run has been busy.
module cnn_layer_sequencer #(
  parameter int MAX_LAYERS = 8,
  parameter int ADDR_W     = 3,
  parameter int FM_W       = 8,
  parameter int KS_W       = 6,
  parameter int KN_W       = 8,
  parameter int CYC_W      = 24,
  parameter int DESC_W     = 4 + FM_W + KS_W + FM_W + 2 + KN_W + KS_W + 1 + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DESC_W-1:0] cfg_wdata,
  input  logic [ADDR_W:0]   cfg_num_layers,
  input  logic              start,
  input  logic              layer_ready,
  output logic [3:0]        layer_type,
  output logic [3:0]        pre_layer_type,
  output logic [3:0]        layer_num,
  output logic [FM_W-1:0]   fm_size,
  output logic [KS_W-1:0]   fm_depth,
  output logic [FM_W-1:0]   fm_size_out,
  output logic [1:0]        padding_out,
  output logic [KN_W-1:0]   kernel_num,
  output logic [KS_W-1:0]   kernel_size,
  output logic              activation,
  output logic              pool_type,
  output logic              busy,
  output logic              done,
  output logic [CYC_W-1:0]  busy_cycles
);

  localparam logic [ADDR_W:0] MAX_N     = (ADDR_W + 1)'(MAX_LAYERS);
  localparam logic [3:0]      TYPE_INIT = 4'd0;
  localparam logic [3:0]      TYPE_DONE = 4'd9;

  typedef struct packed {
    logic [3:0]      ltype;
    logic [FM_W-1:0] fm_size;
    logic [KS_W-1:0] fm_depth;
    logic [FM_W-1:0] fm_size_out;
    logic [1:0]      padding;
    logic [KN_W-1:0] kernel_num;
    logic [KS_W-1:0] kernel_size;
    logic            activation;
    logic            pool_type;
  } desc_t;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  desc_t           table_q [MAX_LAYERS];
  desc_t           table_d [MAX_LAYERS];
  // cur_q.ltype doubles as the layer_type output so INIT (0) and DONE (9) need no extra register
  desc_t           cur_q, cur_d;
  desc_t           sel;
  logic [3:0]      pre_q, pre_d;
  logic [3:0]      num_q, num_d;
  logic [ADDR_W:0] n_q, n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rdy_q, rdy_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic            adv;
  logic            cfg_open;

  assign adv      = layer_ready & ~rdy_q;
  assign rdy_d    = layer_ready;
  assign sel      = table_q[num_q[ADDR_W-1:0]];
  assign cfg_open = (state_q == S_IDLE) || (state_q == S_DONE);

  // Descriptor table writes, only while no run is in progress
  always_comb begin
    table_d = table_q;
    if (cfg_we && cfg_open && ({1'b0, cfg_addr} < MAX_N)) begin
      table_d[cfg_addr] = desc_t'(cfg_wdata);
    end
  end

  // Next-state and output logic for the run sequencer
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pre_d   = pre_q;
    num_d   = num_q;
    n_d     = n_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cyc_d   = (busy_q && (cyc_q != '1)) ? cyc_q + 1'b1 : cyc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_INIT;
          n_d       = (cfg_num_layers > MAX_N) ? MAX_N : cfg_num_layers;
          cur_d.ltype = TYPE_INIT;
          num_d     = 4'd0;
          pre_d     = 4'd0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          cyc_d     = '0;
        end
      end
      S_INIT, S_RUN: begin
        if (adv) begin
          // In INIT num_q is 0, so num_q == n covers the empty-network case too
          if ((num_q == 4'(n_q)) || (sel.ltype == TYPE_DONE)) begin
            state_d     = S_DONE;
            cur_d.ltype = TYPE_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            state_d = S_RUN;
            pre_d   = cur_q.ltype;
            cur_d   = sel;
            num_d   = num_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, table and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      pre_q   <= '0;
      num_q   <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      cyc_q   <= '0;
      for (int i = 0; i < MAX_LAYERS; i++) table_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pre_q   <= pre_d;
      num_q   <= num_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      cyc_q   <= cyc_d;
      table_q <= table_d;
    end
  end

  assign layer_type     = cur_q.ltype;
  assign pre_layer_type = pre_q;
  assign layer_num      = num_q;
  assign fm_size        = cur_q.fm_size;
  assign fm_depth       = cur_q.fm_depth;
  assign fm_size_out    = cur_q.fm_size_out;
  assign padding_out    = cur_q.padding;
  assign kernel_num     = cur_q.kernel_num;
  assign kernel_size    = cur_q.kernel_size;
  assign activation     = cur_q.activation;
  assign pool_type      = cur_q.pool_type;
  assign busy           = busy_q;
  assign done           = done_q;
  assign busy_cycles    = cyc_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb/tb_cnn_layer_sequencer.sv - directed self-checking bench for cnn_layer_sequencer
module tb_cnn_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cfg_we, start, layer_ready;
  logic [2:0]  cfg_addr;
  logic [43:0] cfg_wdata;
  logic [3:0]  cfg_num_layers;

  logic [3:0]  layer_type, pre_layer_type, layer_num;
  logic [7:0]  fm_size, fm_size_out, kernel_num;
  logic [5:0]  fm_depth, kernel_size;
  logic [1:0]  padding_out;
  logic        activation, pool_type, busy, done;
  logic [23:0] busy_cycles;

  logic [3:0]  s_layer_type, s_pre_layer_type, s_layer_num;
  logic [7:0]  s_fm_size, s_fm_size_out, s_kernel_num;
  logic [5:0]  s_fm_depth, s_kernel_size;
  logic [1:0]  s_padding_out;
  logic        s_activation, s_pool_type, s_busy, s_done;
  logic [3:0]  s_busy_cycles;

  cnn_layer_sequencer u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_num_layers(cfg_num_layers), .start(start), .layer_ready(layer_ready),
    .layer_type(layer_type), .pre_layer_type(pre_layer_type), .layer_num(layer_num),
    .fm_size(fm_size), .fm_depth(fm_depth), .fm_size_out(fm_size_out),
    .padding_out(padding_out), .kernel_num(kernel_num), .kernel_size(kernel_size),
    .activation(activation), .pool_type(pool_type), .busy(busy), .done(done),
    .busy_cycles(busy_cycles)
  );

  cnn_layer_sequencer #(.CYC_W(4)) u_sat (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_num_layers(cfg_num_layers), .start(start), .layer_ready(layer_ready),
    .layer_type(s_layer_type), .pre_layer_type(s_pre_layer_type), .layer_num(s_layer_num),
    .fm_size(s_fm_size), .fm_depth(s_fm_depth), .fm_size_out(s_fm_size_out),
    .padding_out(s_padding_out), .kernel_num(s_kernel_num), .kernel_size(s_kernel_size),
    .activation(s_activation), .pool_type(s_pool_type), .busy(s_busy), .done(s_done),
    .busy_cycles(s_busy_cycles)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [43:0] mk_desc(input logic [3:0] t, input logic [7:0] fm,
                                          input logic [5:0] dep, input logic [7:0] fo,
                                          input logic [1:0] pad, input logic [7:0] kn,
                                          input logic [5:0] ks, input logic act, input logic pl);
    return {t, fm, dep, fo, pad, kn, ks, act, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [43:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic rise();
    layer_ready = 1'b1;
    tick();
  endtask

  task automatic fall();
    layer_ready = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; start = 1'b0; layer_ready = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; cfg_num_layers = '0;
    tick(); tick();
    chk("rst_type", layer_type, 0);
    chk("rst_num", layer_num, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cyc", busy_cycles, 0);
    chk("rst_fm", fm_size, 0);
    rst = 1'b1;

    // three-layer conv/pool/fc network
    wr(3'd0, mk_desc(4'd1, 8'd28, 6'd1, 8'd26, 2'd0, 8'd6, 6'd3, 1'b1, 1'b0));
    wr(3'd1, mk_desc(4'd2, 8'd26, 6'd6, 8'd13, 2'd0, 8'd6, 6'd2, 1'b0, 1'b1));
    wr(3'd2, mk_desc(4'd3, 8'd13, 6'd6, 8'd1, 2'd1, 8'd10, 6'd13, 1'b0, 1'b0));
    cfg_num_layers = 4'd3;
    go();
    chk("init_busy", busy, 1);
    chk("init_type", layer_type, 0);
    chk("init_num", layer_num, 0);
    chk("init_cyc", busy_cycles, 0);
    rise();
    chk("l1_num", layer_num, 1);
    chk("l1_type", layer_type, 1);
    chk("l1_pre", pre_layer_type, 0);
    chk("l1_fm", fm_size, 28);
    chk("l1_ks", kernel_size, 3);
    chk("l1_act", activation, 1);
    fall();
    rise();
    chk("l2_num", layer_num, 2);
    chk("l2_type", layer_type, 2);
    chk("l2_pre", pre_layer_type, 1);
    chk("l2_pool", pool_type, 1);
    chk("l2_fo", fm_size_out, 13);
    fall();
    rise();
    chk("l3_num", layer_num, 3);
    chk("l3_type", layer_type, 3);
    chk("l3_pre", pre_layer_type, 2);
    chk("l3_pad", padding_out, 1);
    chk("l3_kn", kernel_num, 10);
    chk("l3_dep", fm_depth, 6);
    fall();
    rise();
    chk("end_type", layer_type, 9);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_num", layer_num, 3);
    chk("end_fm_kept", fm_size, 13);
    fall();
    chk("end_cyc", busy_cycles, 7);
    chk("end_cyc_sat", s_busy_cycles, 7);

    // restart from DONE: start ignored while busy, writes blocked, held ready advances once
    go();
    chk("re_done", done, 0);
    chk("re_busy", busy, 1);
    chk("re_cyc", busy_cycles, 0);
    chk("re_type", layer_type, 0);
    rise();
    chk("re_l1", layer_num, 1);
    fall();
    go();
    chk("start_ignored_num", layer_num, 1);
    chk("start_ignored_type", layer_type, 1);
    wr(3'd2, mk_desc(4'd1, 8'd99, 6'd9, 8'd99, 2'd3, 8'd99, 6'd9, 1'b1, 1'b1));
    layer_ready = 1'b1;
    repeat (20) tick();
    chk("hold_num", layer_num, 2);
    fall();
    rise();
    chk("prot_num", layer_num, 3);
    chk("prot_type", layer_type, 3);
    chk("prot_fm", fm_size, 13);
    chk("long_cyc", busy_cycles, 26);
    chk("sat_cyc", s_busy_cycles, 15);

    // reset in the middle of RUN
    rst = 1'b0; layer_ready = 1'b0;
    tick();
    chk("mid_rst_type", layer_type, 0);
    chk("mid_rst_pre", pre_layer_type, 0);
    chk("mid_rst_num", layer_num, 0);
    chk("mid_rst_fm", fm_size, 0);
    chk("mid_rst_kn", kernel_num, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cyc", busy_cycles, 0);
    chk("mid_rst_sat", s_busy_cycles, 0);
    rst = 1'b1;

    // empty network goes straight from INIT to DONE
    cfg_num_layers = 4'd0;
    go();
    rise();
    chk("n0_type", layer_type, 9);
    chk("n0_num", layer_num, 0);
    chk("n0_done", done, 1);
    chk("n0_busy", busy, 0);
    chk("n0_cyc", busy_cycles, 1);
    fall();

    // type-9 descriptor terminates early
    wr(3'd0, mk_desc(4'd1, 8'd28, 6'd1, 8'd26, 2'd0, 8'd6, 6'd3, 1'b1, 1'b0));
    wr(3'd1, mk_desc(4'd9, 8'd77, 6'd7, 8'd77, 2'd2, 8'd77, 6'd7, 1'b0, 1'b1));
    wr(3'd2, mk_desc(4'd3, 8'd13, 6'd6, 8'd1, 2'd1, 8'd10, 6'd13, 1'b0, 1'b0));
    cfg_num_layers = 4'd3;
    go();
    rise();
    chk("t9_l1", layer_num, 1);
    fall();
    rise();
    chk("t9_type", layer_type, 9);
    chk("t9_num", layer_num, 1);
    chk("t9_done", done, 1);
    chk("t9_fm", fm_size, 28);
    layer_ready = 1'b0;
    repeat (5) tick();
    chk("t9_cyc_frozen", busy_cycles, 3);

    // ready edge in DONE is ignored
    rise();
    chk("done_adv_type", layer_type, 9);
    chk("done_adv_num", layer_num, 1);
    fall();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
